// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS controller:
//   - FSM state encodings (state_t)
//   - opcode / func field constants
//   - ALU function codes and datapath mux select constants
//   - ctrl_t: the bundle of control strobes produced per state
//   - op_is_legal(): opcode legality check used by DECODE
// Optional feature macro: MULTICYCLE_CTRL_JUMP_EN (makes opcode 000010 legal).
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_code;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    // True when DECODE has a successor state for this opcode.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ: legal = 1'b1;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OP_J:                                    legal = 1'b1;
`endif
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the IR fields, memory handshake and all datapath control strobes
// of the multicycle controller.
//   master : the controller (reads op/func/zero/mem_ready, drives controls)
//   slave  : the datapath side (drives op/func/zero/mem_ready, reads controls)
// Parameters: ALUOP_W (alu_op width), STATE_W (state_o width).
// ---------------------------------------------------------------------------
interface multicycle_controller_if #(
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         func;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal_op;
    logic               mem_timeout;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op, func, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, illegal_op, mem_timeout, state_o
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, illegal_op, mem_timeout, state_o
    );
endinterface

// File: rtl/mc_alu_decode.sv
// ---------------------------------------------------------------------------
// mc_alu_decode
// Combinational R-type func decoder.
//   func         in  6  func field (latched copy from the controller)
//   alu_code     out 3  ALU function code (ADD for unsupported func)
//   func_illegal out 1  func is not one of ADD/SUB/AND/OR/SLT
// ---------------------------------------------------------------------------
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_code,
    output logic       func_illegal
);

    // Map func to an ALU code; anything unknown is flagged.
    always_comb begin
        alu_code     = ALU_ADD;
        func_illegal = 1'b0;
        case (func)
            FN_ADD:  alu_code = ALU_ADD;
            FN_SUB:  alu_code = ALU_SUB;
            FN_AND:  alu_code = ALU_AND;
            FN_OR:   alu_code = ALU_OR;
            FN_SLT:  alu_code = ALU_SLT;
            default: begin
                alu_code     = ALU_ADD;
                func_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing each MIPS instruction through FETCH / DECODE /
// EXECUTE / MEM / WB, with a bounded wait on the memory-ready handshake.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   bus    multicycle_controller_if.master (IR fields, zero, mem_ready in;
//          all datapath control strobes, illegal_op, mem_timeout, state_o out)
// Parameters: ALUOP_W, STATE_W, TIMEOUT (max wait cycles per memory state),
//             CNT_W (wait counter width).
// Optional feature macro: MULTICYCLE_CTRL_JUMP_EN builds the JUMP state.
// ---------------------------------------------------------------------------
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_next_s;
    logic [5:0]       op_r;
    logic [5:0]       func_r;
    logic             wait_state_s;
    logic             timeout_s;
    logic             op_legal_s;
    logic [2:0]       alu_code_s;
    logic             func_illegal_s;
    ctrl_t            ctrl_s;
    ctrl_t            ctrl_out_s;

    mc_alu_decode u_alu_decode (
        .func         (func_r),
        .alu_code     (alu_code_s),
        .func_illegal (func_illegal_s)
    );

    // Memory-wait bookkeeping: counter runs only while a memory state stalls.
    always_comb begin
        wait_state_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) ||
                       (state_r == S_MEM_WR);
        // The cycle that would make TIMEOUT stalled cycles is the last one.
        if (wait_state_s && !bus.mem_ready && (wait_cnt_r == CNT_W'(TIMEOUT - 1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        // Any exit, completion or timeout retry restarts the count from zero.
        if (wait_state_s && !bus.mem_ready && !timeout_s) begin
            wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_next_s = {CNT_W{1'b0}};
        end
        op_legal_s = op_is_legal(bus.op);
    end

    // State register, wait counter and DECODE-time op/func latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            op_r       <= 6'd0;
            func_r     <= 6'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (state_r == S_DECODE) begin
                op_r   <= bus.op;
                func_r <= bus.func;
            end else begin
                op_r   <= op_r;
                func_r <= func_r;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = S_FETCH;
            S_FETCH: begin
                if (timeout_s) begin
                    state_next_s = S_FETCH;
                end else if (bus.mem_ready) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:     state_next_s = S_EXEC_R;
                    OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
                    OP_ADDI:      state_next_s = S_EXEC_I;
                    OP_BEQ:       state_next_s = S_BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                    OP_J:         state_next_s = S_JUMP;
`endif
                    default:      state_next_s = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                if (func_illegal_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_R_WB;
                end
            end
            S_R_WB:     state_next_s = S_FETCH;
            S_EXEC_I:   state_next_s = S_I_WB;
            S_I_WB:     state_next_s = S_FETCH;
            S_MEM_ADDR: begin
                // Only lw and sw reach here, so anything not lw is a store.
                if (op_r == OP_LW) begin
                    state_next_s = S_MEM_RD;
                end else begin
                    state_next_s = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (timeout_s) begin
                    state_next_s = S_FETCH;
                end else if (bus.mem_ready) begin
                    state_next_s = S_MEM_WB;
                end else begin
                    state_next_s = S_MEM_RD;
                end
            end
            S_MEM_WB: state_next_s = S_FETCH;
            S_MEM_WR: begin
                if (timeout_s || bus.mem_ready) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEM_WR;
                end
            end
            S_BRANCH: state_next_s = S_FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP:   state_next_s = S_FETCH;
`endif
            default:  state_next_s = S_IDLE;
        endcase
    end

    // Output decode from the registered state; forced quiet while in reset.
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            S_IDLE: ctrl_s = '0;
            S_FETCH: begin
                ctrl_s.mem_read    = 1'b1;
                ctrl_s.ir_write    = bus.mem_ready;
                ctrl_s.pc_write    = bus.mem_ready;
                ctrl_s.alu_src_b   = SRCB_FOUR;
                ctrl_s.alu_code    = ALU_ADD;
                ctrl_s.pc_source   = PCSRC_ALU;
                ctrl_s.mem_timeout = timeout_s;
            end
            S_DECODE: begin
                ctrl_s.alu_src_b  = SRCB_IMM_SH2;
                ctrl_s.alu_code   = ALU_ADD;
                ctrl_s.illegal_op = ~op_legal_s;
            end
            S_EXEC_R: begin
                ctrl_s.alu_src_a  = 1'b1;
                ctrl_s.alu_src_b  = SRCB_RT;
                ctrl_s.alu_code   = alu_code_s;
                ctrl_s.illegal_op = func_illegal_s;
            end
            S_R_WB: begin
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.reg_write = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_code  = ALU_ADD;
            end
            S_I_WB: ctrl_s.reg_write = 1'b1;
            S_MEM_RD: begin
                ctrl_s.mem_read    = 1'b1;
                ctrl_s.i_or_d      = 1'b1;
                ctrl_s.mem_timeout = timeout_s;
            end
            S_MEM_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_s.mem_write   = 1'b1;
                ctrl_s.i_or_d      = 1'b1;
                ctrl_s.mem_timeout = timeout_s;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a     = 1'b1;
                ctrl_s.alu_src_b     = SRCB_RT;
                ctrl_s.alu_code      = ALU_SUB;
                ctrl_s.pc_write_cond = 1'b1;
                ctrl_s.pc_source     = PCSRC_ALUOUT;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.pc_source = PCSRC_JUMP;
            end
`endif
            default: ctrl_s = '0;
        endcase
        if (rst_n) begin
            ctrl_out_s = ctrl_s;
        end else begin
            ctrl_out_s = '0;
        end
    end

    assign bus.pc_write      = ctrl_out_s.pc_write;
    assign bus.pc_write_cond = ctrl_out_s.pc_write_cond;
    assign bus.i_or_d        = ctrl_out_s.i_or_d;
    assign bus.mem_read      = ctrl_out_s.mem_read;
    assign bus.mem_write     = ctrl_out_s.mem_write;
    assign bus.ir_write      = ctrl_out_s.ir_write;
    assign bus.mem_to_reg    = ctrl_out_s.mem_to_reg;
    assign bus.reg_dst       = ctrl_out_s.reg_dst;
    assign bus.reg_write     = ctrl_out_s.reg_write;
    assign bus.alu_src_a     = ctrl_out_s.alu_src_a;
    assign bus.alu_src_b     = ctrl_out_s.alu_src_b;
    assign bus.pc_source     = ctrl_out_s.pc_source;
    assign bus.alu_op        = ALUOP_W'(ctrl_out_s.alu_code);
    assign bus.illegal_op    = ctrl_out_s.illegal_op;
    assign bus.mem_timeout   = ctrl_out_s.mem_timeout;
    assign bus.state_o       = rst_n ? STATE_W'(state_r) : {STATE_W{1'b0}};

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench for multicycle_controller: a table of instruction
// records with hand-derived cycle counts and flags, a randomized instruction
// stream checked cycle by cycle against a transaction-level model, and hand
// sequences for reset release and reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int TIMEOUT = 15;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
        logic       mem_timeout;
        logic [3:0] state;
    } exp_t;

    typedef struct {
        logic       rdy;
        logic [5:0] op;
        logic [5:0] func;
        exp_t       e;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        int         delay;
        int         cycles;
        logic       rw;
        logic       il;
        logic       to;
        int         mw;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    cyc_t q[$];
    rec_t tab[12];
    logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    multicycle_controller_if #(.ALUOP_W(3), .STATE_W(4)) bus ();

    multicycle_controller #(
        .ALUOP_W(3), .STATE_W(4), .TIMEOUT(TIMEOUT), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t sample();
        exp_t s;
        s.pc_write      = bus.pc_write;
        s.pc_write_cond = bus.pc_write_cond;
        s.i_or_d        = bus.i_or_d;
        s.mem_read      = bus.mem_read;
        s.mem_write     = bus.mem_write;
        s.ir_write      = bus.ir_write;
        s.mem_to_reg    = bus.mem_to_reg;
        s.reg_dst       = bus.reg_dst;
        s.reg_write     = bus.reg_write;
        s.alu_src_a     = bus.alu_src_a;
        s.alu_src_b     = bus.alu_src_b;
        s.pc_source     = bus.pc_source;
        s.alu_op        = bus.alu_op;
        s.illegal_op    = bus.illegal_op;
        s.mem_timeout   = bus.mem_timeout;
        s.state         = bus.state_o;
        return s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Moore outputs each state is documented to assert.
    function automatic exp_t base(input logic [3:0] st);
        exp_t e = '0;
        e.state = st;
        case (st)
            4'd1:  begin e.mem_read = 1'b1; e.alu_src_b = 2'd1; end
            4'd2:  e.alu_src_b = 2'd3;
            4'd3:  e.alu_src_a = 1'b1;
            4'd4:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            4'd5:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
            4'd6:  e.reg_write = 1'b1;
            4'd7:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
            4'd8:  begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
            4'd9:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            4'd10: begin e.mem_write = 1'b1; e.i_or_d = 1'b1; end
            4'd11: begin e.alu_src_a = 1'b1; e.alu_op = 3'd1;
                         e.pc_write_cond = 1'b1; e.pc_source = 2'd1; end
            4'd12: begin e.pc_write = 1'b1; e.pc_source = 2'd2; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic void push(input logic rdy, input logic [5:0] op,
                                 input logic [5:0] func, input exp_t e);
        cyc_t c;
        c.rdy = rdy; c.op = op; c.func = func; c.e = e;
        q.push_back(c);
    endfunction

    // Cycle where inputs other than the expected ones must be ignored.
    function automatic void push_n(input exp_t e);
        push(1'($urandom), 6'($urandom), 6'($urandom), e);
    endfunction

    // A memory state that sees mem_ready after 'delay' stalled cycles,
    // giving up after TIMEOUT cycles in the state.
    task automatic m_wait(input logic [3:0] st, input int delay, output logic ok);
        exp_t e;
        logic rdy;
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            e   = base(st);
            rdy = (i >= delay);
            if (st == 4'd1) begin
                e.pc_write = rdy;
                e.ir_write = rdy;
            end
            if (!rdy && i == TIMEOUT - 1) e.mem_timeout = 1'b1;
            push(rdy, 6'($urandom), 6'($urandom), e);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic m_instr(input logic [5:0] op, input logic [5:0] func,
                           input int fd, input int md);
        exp_t e;
        logic ok;
        logic legal;
        int   code;
        int   d;
        ok = 1'b0;
        d  = fd;
        while (!ok) begin
            m_wait(4'd1, d, ok);
            d = 0;
        end
        legal = (op == T_RTYPE) || (op == T_LW) || (op == T_SW) ||
                (op == T_ADDI) || (op == T_BEQ);
`ifdef MULTICYCLE_CTRL_JUMP_EN
        legal = legal || (op == T_J);
`endif
        e = base(4'd2);
        e.illegal_op = ~legal;
        push(1'($urandom), op, func, e);
        if (legal) begin
            case (op)
                T_RTYPE: begin
                    code = -1;
                    for (int i = 0; i < 5; i++) if (func == fn_tab[i]) code = i;
                    e = base(4'd3);
                    if (code < 0) e.illegal_op = 1'b1;
                    else          e.alu_op = 3'(code);
                    push_n(e);
                    if (code >= 0) push_n(base(4'd4));
                end
                T_LW: begin
                    push_n(base(4'd7));
                    m_wait(4'd8, md, ok);
                    if (ok) push_n(base(4'd9));
                end
                T_SW: begin
                    push_n(base(4'd7));
                    m_wait(4'd10, md, ok);
                end
                T_ADDI: begin
                    push_n(base(4'd5));
                    push_n(base(4'd6));
                end
                T_BEQ:   push_n(base(4'd11));
                default: push_n(base(4'd12));
            endcase
        end
    endtask

    // Run one table record starting in FETCH; stalls in MEM_RD/MEM_WR
    // for r.delay cycles and gathers what the instruction did.
    task automatic run_rec(input int idx);
        rec_t r;
        int   n, mw, in_st;
        logic rw, il, to;
        logic [3:0] st, st_nx;
        r = tab[idx];
        n = 0; mw = 0; in_st = 0;
        rw = 1'b0; il = 1'b0; to = 1'b0;
        st = bus.state_o;
        chk($sformatf("rec%0d start state", idx), int'(st), 1);
        do begin
            bus.zero = 1'($urandom);
            if (st == 4'd2) begin
                bus.op   = r.op;
                bus.func = r.func;
            end else begin
                bus.op   = 6'($urandom);
                bus.func = 6'($urandom);
            end
            if (st == 4'd8 || st == 4'd10) bus.mem_ready = (in_st >= r.delay);
            else                           bus.mem_ready = 1'b1;
            #1;
            if (n == 0) chk($sformatf("rec%0d fetch pc/ir write", idx),
                            int'({bus.pc_write, bus.ir_write}), 3);
            rw = rw | bus.reg_write;
            il = il | bus.illegal_op;
            to = to | bus.mem_timeout;
            if (bus.mem_write) mw++;
            n++;
            @(negedge clk);
            st_nx = bus.state_o;
            in_st = (st_nx == st) ? in_st + 1 : 0;
            st    = st_nx;
        end while (st != 4'd1 && n < 64);
        if (n >= 64) chk($sformatf("rec%0d cycle bound", idx), n, -1);
        chk($sformatf("rec%0d cycles", idx), n, r.cycles);
        chk($sformatf("rec%0d reg_write seen", idx), int'(rw), int'(r.rw));
        chk($sformatf("rec%0d illegal_op seen", idx), int'(il), int'(r.il));
        chk($sformatf("rec%0d mem_timeout seen", idx), int'(to), int'(r.to));
        chk($sformatf("rec%0d mem_write cycles", idx), mw, r.mw);
    endtask

    initial begin
        exp_t got, want;
        logic [5:0] op, func;
        int pick;

        //            op       func          dly cyc rw    il    to    mw
        tab[0]  = '{T_LW,    6'b100000,  0,  5, 1'b1, 1'b0, 1'b0, 0};
        tab[1]  = '{T_SW,    6'b100000,  0,  4, 1'b0, 1'b0, 1'b0, 1};
        tab[2]  = '{T_RTYPE, 6'b100010,  0,  4, 1'b1, 1'b0, 1'b0, 0};
        tab[3]  = '{T_RTYPE, 6'b111111,  0,  3, 1'b0, 1'b1, 1'b0, 0};
        tab[4]  = '{T_ADDI,  6'b000000,  0,  4, 1'b1, 1'b0, 1'b0, 0};
        tab[5]  = '{T_BEQ,   6'b000000,  0,  3, 1'b0, 1'b0, 1'b0, 0};
        tab[6]  = '{6'b111111, 6'b100000, 0, 2, 1'b0, 1'b1, 1'b0, 0};
`ifdef MULTICYCLE_CTRL_JUMP_EN
        tab[7]  = '{T_J,     6'b000000,  0,  3, 1'b0, 1'b0, 1'b0, 0};
`else
        tab[7]  = '{T_J,     6'b000000,  0,  2, 1'b0, 1'b1, 1'b0, 0};
`endif
        tab[8]  = '{T_SW,    6'b000000, 99, 18, 1'b0, 1'b0, 1'b1, 15};
        tab[9]  = '{T_SW,    6'b000000, 14, 18, 1'b0, 1'b0, 1'b0, 15};
        tab[10] = '{T_LW,    6'b000000, 15, 18, 1'b0, 1'b0, 1'b1, 0};
        tab[11] = '{T_LW,    6'b000000,  3,  8, 1'b1, 1'b0, 1'b0, 0};

        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.op = 6'd0;
        bus.func = 6'd0;
        bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_vec("reset outputs", sample(), '0);

        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_vec("idle after release", sample(), '0);
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_rec(i);

        // Randomized instruction stream against the model.
        q.delete();
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 6);
            case (pick)
                0: op = T_RTYPE;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_ADDI;
                4: op = T_BEQ;
                5: op = T_J;
                default: op = 6'($urandom);
            endcase
            if ($urandom_range(0, 3) != 0) func = fn_tab[$urandom_range(0, 4)];
            else                           func = 6'($urandom);
            m_instr(op, func,
                    ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 2),
                    $urandom_range(0, 18));
        end
        for (int k = 0; k < q.size(); k++) begin
            bus.mem_ready = q[k].rdy;
            bus.op        = q[k].op;
            bus.func      = q[k].func;
            bus.zero      = 1'($urandom);
            #1;
            got  = sample();
            want = q[k].e;
            // alu_op is unspecified when EXEC_R rejects the func.
            if (want.state == 4'd3 && want.illegal_op) want.alu_op = got.alu_op;
            chk_vec($sformatf("model cycle %0d", k), got, want);
            @(negedge clk);
        end

        // Reset while a load is waiting in MEM_RD.
        bus.mem_ready = 1'b1;
        bus.op = T_LW;
        #1 chk("mid-reset seq fetch", int'(bus.state_o), 1);
        @(negedge clk);
        #1 chk("mid-reset seq decode", int'(bus.state_o), 2);
        @(negedge clk);
        bus.op = 6'($urandom);
        #1 chk("mid-reset seq mem_addr", int'(bus.state_o), 7);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 chk("mid-reset seq mem_rd", int'({bus.state_o, bus.mem_read, bus.i_or_d}), 35);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 chk_vec("reset during MEM_RD", sample(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        #1 chk("post-reset idle", int'(bus.state_o), 0);
        @(negedge clk);
        #1 chk("post-reset fetch", int'({bus.state_o, bus.pc_write}), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM controller for the multicycle MIPS datapath. It generalises the single-cycle op/func decoder to a sequenced one.
- Decodes the 6-bit op and func fields and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Waits on a memory-ready handshake and enforces a bounded memory timeout.
- Sits between the instruction register and the datapath muxes, register file, ALU and memory port.

Parameters:
ALUOP_W, 3, width of alu_op; must be >= 3; codes zero-extended.
STATE_W, 4, width of the state register and state_o.
TIMEOUT, 15, max cycles spent waiting for mem_ready in one memory state; must be >= 1.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
op  in  6  instruction[31:26], from IR
func  in  6  instruction[5:0], from IR
zero  in  1  ALU zero flag (branch compare)
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  load IR
mem_to_reg  out  1  writeback source: 1=MDR
reg_dst  out  1  destination: 1=rd, 0=rt
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
alu_op  out  ALUOP_W  ALU function code
illegal_op  out  1  one-cycle pulse on unsupported opcode/func
mem_timeout  out  1  one-cycle pulse on memory wait overrun
state_o  out  STATE_W  current state, for debug

Behaviour:
- Synchronous active-low reset, one clock (clk); rst_n sampled on the rising edge of clk.
- Reset: state=IDLE, counter=0, latched op/func=0.
  - All outputs are 0 during reset and in IDLE; state_o=0.
- Output timing: outputs decode from the registered state (Moore), so every output is 0 in IDLE.
  - Exception: in EXEC_R, alu_op decodes from func latched in DECODE.
- op/func are captured into internal registers on the DECODE cycle. IR changes after DECODE are ignored.
- State encoding and transitions:
  - IDLE(0) -> FETCH.
  - FETCH(1): mem_read, ir_write, alu_src_b=1, alu_op=ADD, pc_source=0.
    - pc_write and ir_write are qualified by mem_ready.
    - Holds until mem_ready, then -> DECODE.
  - DECODE(2): alu_src_b=3, alu_op=ADD (branch target precompute). Next state by op:
    - 000000 -> EXEC_R
    - 100011 (lw) / 101011 (sw) -> MEM_ADDR
    - 001000 (addi) -> EXEC_I
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP, only when the feature is enabled
    - anything else -> FETCH, with an illegal_op pulse.
  - EXEC_R(3): alu_src_a=1, alu_src_b=0, alu_op from func:
    - 100000 ADD=0, 100010 SUB=1, 100100 AND=2, 100101 OR=3, 101010 SLT=4.
    - Other func -> illegal_op pulse, -> FETCH, no write.
    - Otherwise -> R_WB.
  - R_WB(4): reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH.
  - EXEC_I(5): alu_src_a=1, alu_src_b=2, alu_op=ADD -> I_WB.
  - I_WB(6): reg_dst=0, reg_write=1 -> FETCH.
  - MEM_ADDR(7): alu_src_a=1, alu_src_b=2, alu_op=ADD -> MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(8): mem_read, i_or_d=1. Holds until mem_ready -> MEM_WB.
  - MEM_WB(9): reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEM_WR(10): mem_write, i_or_d=1. Holds until mem_ready -> FETCH.
  - BRANCH(11): alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_source=1 -> FETCH.
  - JUMP(12): pc_write, pc_source=2 -> FETCH.
- Wait counter, active in FETCH, MEM_RD and MEM_WR:
  - Cleared on entering any of these states; increments each cycle mem_ready=0.
  - If the counter reaches TIMEOUT with mem_ready still 0: mem_timeout pulses that cycle and the state -> FETCH (a retry from the current PC).
    - The strobes deassert the next cycle. No pc_write, ir_write or reg_write occurs.
  - mem_ready=1 on the same cycle the counter hits TIMEOUT: the access completes; no timeout.
- mem_ready outside the memory states is ignored.
- Reset mid-instruction aborts immediately: IDLE next edge, no partial writes.
- Illegal state encodings -> IDLE.

Optional Feature:
MULTICYCLE_CTRL_JUMP_EN
- Defined: opcode 000010 decodes to JUMP as specified above.
- Undefined: the JUMP state is not built; 000010 is treated as illegal (illegal_op pulse, -> FETCH).

Decomposition:
- Package mc_ctrl_pkg:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J)
  - func constants
  - ALU code constants (ALU_ADD..ALU_SLT)
  - alu_src_b and pc_source select constants.
- One sub-module, mc_alu_decode: combinational func -> {alu_op, func_illegal}, reused in EXEC_R.

Test Plan:
- Reset then release, mem_ready=1: IDLE 1 cycle -> FETCH; pc_write=ir_write=1; DECODE next.
- lw (op=100011), mem_ready=1 throughout:
  - FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB = 5 cycles; reg_write=1 with mem_to_reg=1 in cycle 5.
- R-type SUB (func=100010):
  - alu_op=1 in EXEC_R; reg_write=1, reg_dst=1 in R_WB; 4 cycles total.
  - func=111111 -> illegal_op pulse, no reg_write.
- beq with zero=1: pc_write_cond=1, pc_source=1 in BRANCH; 3 cycles total.
- sw with mem_ready held 0, TIMEOUT=15:
  - mem_write high for 15 cycles of MEM_WR, then mem_timeout pulse and FETCH.
  - Repeat with mem_ready rising on wait cycle 15 -> completes, no timeout.
- op=000010: with macro, JUMP state asserts pc_write, pc_source=2; without macro, illegal_op pulse. rst_n=0 during MEM_RD -> IDLE next edge, all outputs 0.
